// File: rtl/uart_tx_fifo_if.sv
// Handshake/status bundle between a byte producer and the UART transmitter.
// No logic here: width parameters must match the attached uart_tx_fifo instance.
// master drives bytes and strobes; slave drives the serial line and FIFO status.
interface uart_tx_fifo_if #(
    parameter int DATA_BITS = 8,
    parameter int FIFO_AW   = 4
) ();
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_trig;
    logic                 rs232_tx;
    logic                 tx_en;
    logic                 tx_done;
    logic                 tx_full;
    logic                 tx_empty;
    logic                 tx_ovf;
    logic [FIFO_AW:0]     tx_level;

    modport master (
        output tx_data, tx_trig,
        input  rs232_tx, tx_en, tx_done, tx_full, tx_empty, tx_ovf, tx_level
    );

    modport slave (
        input  tx_data, tx_trig,
        output rs232_tx, tx_en, tx_done, tx_full, tx_empty, tx_ovf, tx_level
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a 2**FIFO_AW-deep byte FIFO, parity and stop bits configurable.
// Latency: start bit hits the line 2 cycles after a write that finds FIFO empty and line idle.
// Backpressure: none upstream; a write while full is dropped and flagged by a tx_ovf pulse.
module uart_tx_fifo #(
    parameter int CLK_DIV   = 868,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1,
    parameter int FIFO_AW   = 4
) (
    input logic           sclk,
    input logic           srst,
    uart_tx_fifo_if.slave bus
);
    localparam int                 DEPTH     = 2 ** FIFO_AW;
    localparam int                 CW        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0]      BAUD_LAST = CW'(CLK_DIV - 1);
    localparam logic [2:0]         DATA_LAST = 3'(DATA_BITS - 1);
    localparam logic [2:0]         STOP_LAST = 3'(STOP_BITS - 1);
    localparam logic [FIFO_AW:0]   LVL_FULL  = (FIFO_AW + 1)'(DEPTH);
    localparam logic [FIFO_AW:0]   LVL_ONE   = (FIFO_AW + 1)'(1);
    localparam logic               ODD       = (PARITY == 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    // FIFO storage and occupancy
    logic [DATA_BITS-1:0] mem [DEPTH];
    logic [FIFO_AW-1:0]   wr_ptr;
    logic [FIFO_AW-1:0]   rd_ptr;
    logic [FIFO_AW:0]     level;
    logic                 armed;
    logic                 ovf_q;
    logic                 full;
    logic                 empty;
    logic                 push;
    logic                 pop;
    logic [DATA_BITS-1:0] head;

    // Transmit engine
    state_t               state;
    logic [CW-1:0]        baud;
    logic [2:0]           bit_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bit;
    logic                 line_q;
    logic                 en_q;
    logic                 done_q;
    logic                 bit_end;
    logic                 frame_end;

    // Full/empty come from the registered level, so a write sees fullness before any same-cycle pop.
    assign full      = (level == LVL_FULL);
    assign empty     = (level == '0);
    assign push      = bus.tx_trig && armed && !full;
    assign head      = mem[rd_ptr];
    assign bit_end   = (baud == BAUD_LAST);
    assign frame_end = (state == ST_STOP) && bit_end && (bit_idx == STOP_LAST);

    // Pop when idle with data waiting, or at the very end of a frame to chain the next one.
    always_comb begin
        pop = 1'b0;
        if (!empty) begin
            pop = (state == ST_IDLE) || frame_end;
        end
    end

    // FIFO data array; contents need no reset because the pointers define validity.
    always_ff @(posedge sclk) begin
        if (push) begin
            mem[wr_ptr] <= bus.tx_data;
        end
    end

    // Pointers, occupancy, overflow pulse and the post-reset write mask.
    always_ff @(posedge sclk or negedge srst) begin
        if (!srst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            armed  <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            armed <= 1'b1;
            ovf_q <= bus.tx_trig && armed && full;
            if (push) begin
                wr_ptr <= wr_ptr + FIFO_AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + FIFO_AW'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + LVL_ONE;
                2'b01:   level <= level - LVL_ONE;
                default: level <= level;
            endcase
        end
    end

    // Frame sequencer; line, enable and done are registered from the current state,
    // so the line trails the state by one cycle uniformly and every bit stays CLK_DIV long.
    always_ff @(posedge sclk or negedge srst) begin
        if (!srst) begin
            state   <= ST_IDLE;
            baud    <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            par_bit <= 1'b0;
            line_q  <= 1'b1;
            en_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state)
                ST_START:  line_q <= 1'b0;
                ST_DATA:   line_q <= shreg[0];
                ST_PARITY: line_q <= par_bit;
                default:   line_q <= 1'b1;
            endcase
            en_q   <= (state != ST_IDLE);
            done_q <= frame_end;

            if (state == ST_IDLE) begin
                baud    <= '0;
                bit_idx <= '0;
                if (pop) begin
                    shreg   <= head;
                    par_bit <= (^head) ^ ODD;
                    state   <= ST_START;
                end
            end else if (bit_end) begin
                baud <= '0;
                case (state)
                    ST_START: begin
                        bit_idx <= '0;
                        state   <= ST_DATA;
                    end
                    ST_DATA: begin
                        shreg <= {1'b0, shreg[DATA_BITS-1:1]};
                        if (bit_idx == DATA_LAST) begin
                            bit_idx <= '0;
                            state   <= (PARITY != 0) ? ST_PARITY : ST_STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end
                    ST_PARITY: begin
                        bit_idx <= '0;
                        state   <= ST_STOP;
                    end
                    default: begin
                        if (bit_idx == STOP_LAST) begin
                            bit_idx <= '0;
                            if (pop) begin
                                shreg   <= head;
                                par_bit <= (^head) ^ ODD;
                                state   <= ST_START;
                            end else begin
                                state   <= ST_IDLE;
                            end
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end
                endcase
            end else begin
                baud <= baud + CW'(1);
            end
        end
    end

    assign bus.rs232_tx = line_q;
    assign bus.tx_en    = en_q;
    assign bus.tx_done  = done_q;
    assign bus.tx_full  = full;
    assign bus.tx_empty = empty;
    assign bus.tx_ovf   = ovf_q;
    assign bus.tx_level = level;
endmodule
